// File: rtl/switch_box_cfg_pkg.sv
// Shared state encodings and counter-width helper for the switch-box config loader.
package switch_box_cfg_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Bits needed to hold a down-counter that starts at max_val and stops at 0.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Load/shift register for one configuration word with a count of bits still to emit.
module cfg_word_serializer
  import switch_box_cfg_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_load_cnt,
  output logic              o_next_bit_c,
  output logic              o_last_c
);

  logic [WORD_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_word_left;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  w_left_nxt;

  always_comb begin
    w_shreg_nxt = r_shreg;
    w_left_nxt  = r_word_left;
    if (i_load) begin
      w_shreg_nxt = i_data;
      w_left_nxt  = i_load_cnt;
    end else if (i_shift) begin
      w_shreg_nxt = r_shreg >> 1;
      if (r_word_left != '0) begin
        w_left_nxt = r_word_left - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_word_left <= '0;
    end else begin
      r_shreg     <= w_shreg_nxt;
      r_word_left <= w_left_nxt;
    end
  end

  // Bit that will sit at the chain-facing end after this edge; lets the top register cfg_out.
  assign o_next_bit_c = w_shreg_nxt[0];
  assign o_last_c     = (r_word_left == CNT_W'(1));

endmodule

// File: rtl/switch_box_config_loader.sv
// Streams configuration words LSB-first onto the switch-box config chain and strobes commit
// once exactly CHAIN_LEN bits have been shifted.
module switch_box_config_loader
  import switch_box_cfg_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_en,
  output logic              cfg_out,
  output logic              cfg_commit,
  output logic              busy,
  output logic              cfg_done
);

  localparam int unsigned REM_W = cnt_w(CHAIN_LEN);
  localparam int unsigned WL_W  = cnt_w(WORD_W);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [REM_W-1:0] r_remaining;
  logic [REM_W-1:0] w_rem_nxt;
  logic [WL_W-1:0]  w_load_cnt;
  logic             w_load;
  logic             w_shift;
  logic             w_next_bit;
  logic             w_last;

  logic r_in_ready;
  logic r_cfg_en;
  logic r_cfg_out;
  logic r_cfg_commit;
  logic r_busy;
  logic r_cfg_done;

  // Final word of the load only contributes the bits the chain still needs.
  assign w_load_cnt = (32'(r_remaining) >= WORD_W) ? WL_W'(WORD_W) : WL_W'(r_remaining);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_FILL;
          w_rem_nxt   = REM_W'(CHAIN_LEN);
        end
      end
      ST_FILL: begin
        if (in_valid && r_in_ready) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_remaining != '0) begin
          w_rem_nxt = r_remaining - REM_W'(1);
        end
        if (r_remaining == REM_W'(1)) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_last) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_COMMIT: w_state_nxt = ST_DONE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (WL_W)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_shift      (w_shift),
    .i_data       (in_data),
    .i_load_cnt   (w_load_cnt),
    .o_next_bit_c (w_next_bit),
    .o_last_c     (w_last)
  );

  // Outputs are registered from the next state so each one lines up with the state it decodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_in_ready   <= 1'b0;
      r_cfg_en     <= 1'b0;
      r_cfg_out    <= 1'b0;
      r_cfg_commit <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_rem_nxt;
      r_in_ready   <= (w_state_nxt == ST_FILL);
      r_cfg_en     <= (w_state_nxt == ST_SHIFT);
      r_cfg_out    <= (w_state_nxt == ST_SHIFT) && w_next_bit;
      r_cfg_commit <= (w_state_nxt == ST_COMMIT);
      r_busy       <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_SHIFT) ||
                      (w_state_nxt == ST_COMMIT);
      r_cfg_done   <= (w_state_nxt == ST_DONE);
    end
  end

  assign in_ready   = r_in_ready;
  assign cfg_en     = r_cfg_en;
  assign cfg_out    = r_cfg_out;
  assign cfg_commit = r_cfg_commit;
  assign busy       = r_busy;
  assign cfg_done   = r_cfg_done;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Self-checking bench for switch_box_config_loader: table-driven loads, reset cases and
// randomized loads scored against a per-cycle shift schedule model.
module tb_switch_box_config_loader;

  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CHAIN_LEN = 20;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_en;
  logic              cfg_out;
  logic              cfg_commit;
  logic              busy;
  logic              cfg_done;

  switch_box_config_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_en     (cfg_en),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .busy       (busy),
    .cfg_done   (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected shift schedule: which cycles carry cfg_en and the bit on each.
  bit exp_en  [0:127];
  bit exp_bit [0:127];

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
    int          gap;
    int          mode;
    logic [19:0] exp_bits;
    int          exp_commit;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // mode 0: plain always-valid source; 1: start held and junk valid outside FILL; 2: random.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int gap, input int mode, input int abort, input bit prev_done,
                          input logic [19:0] exp_bits, input int exp_commit, input string tag);
    logic [7:0]  words [3];
    logic [19:0] cap;
    int c, widx, rem, last_en, stall, en_cnt, commit_at, k;
    bit fin, v;
    words[0] = w0; words[1] = w1; words[2] = w2;
    for (int i = 0; i < 128; i++) begin exp_en[i] = 1'b0; exp_bit[i] = 1'b0; end
    rem = CHAIN_LEN; last_en = 0; widx = 0; stall = 0; en_cnt = 0; commit_at = -1; cap = '0;
    for (c = 0; c < 80; c++) begin
      @(negedge clk);
      if (abort >= 0 && c > abort) begin
        check({tag, " rst_outs"},
              int'({in_ready, cfg_en, cfg_out, cfg_commit, busy, cfg_done}), 0);
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        if (c >= abort + 3) break;
        continue;
      end
      fin = (rem == 0) && (c >= last_en + 2);
      check({tag, " cfg_en"}, int'(cfg_en), int'(exp_en[c]));
      if (exp_en[c]) check({tag, " cfg_out"}, int'(cfg_out), int'(exp_bit[c]));
      check({tag, " commit"}, int'(cfg_commit), int'(rem == 0 && c == last_en + 1));
      check({tag, " busy"}, int'(busy), int'(c >= 1 && !fin));
      check({tag, " done"}, int'(cfg_done), (c == 0) ? int'(prev_done) : int'(fin));
      if (mode != 2)
        check({tag, " in_ready"}, int'(in_ready),
              int'(c == 1 || (c >= 10 && c <= 10 + gap) || c == 19 + gap));
      if (cfg_en && en_cnt < 20) cap[en_cnt] = cfg_out;
      if (cfg_en) en_cnt++;
      if (cfg_commit && commit_at < 0) commit_at = c;
      if (fin && c >= last_en + 3) break;
      // drive inputs for this cycle
      if (c == 0) start = 1'b1;
      else if (mode == 0) start = 1'b0;
      else if (mode == 1) start = !fin;
      else start = !fin && ($urandom_range(0, 1) == 1);
      if (in_ready && widx < 3) begin
        if (mode == 2) v = ($urandom_range(0, 2) != 0);
        else if (widx == 1 && stall < gap) begin v = 1'b0; stall++; end
        else v = 1'b1;
        in_valid = v;
        in_data  = words[widx];
        if (v) begin
          k = (rem > 8) ? 8 : rem;
          for (int j = 0; j < k; j++) begin
            exp_en[c + 1 + j]  = 1'b1;
            exp_bit[c + 1 + j] = words[widx][j];
          end
          rem     = rem - k;
          last_en = c + k;
          widx++;
        end
      end else if (mode == 0) begin
        in_valid = (c >= 1 && widx < 3);
        in_data  = (widx < 3) ? words[widx] : 8'h00;
      end else if (mode == 1) begin
        in_valid = 1'b1;
        in_data  = 8'hEE;
      end else begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = 8'($urandom);
      end
      if (c == abort) rst_n = 1'b0;
    end
    if (c >= 80) check({tag, " timeout"}, c, 0);
    if (abort < 0) begin
      check({tag, " words_used"}, widx, 3);
      check({tag, " en_cycles"}, en_cnt, int'(CHAIN_LEN));
      check({tag, " bits"}, int'(cap), int'(exp_bits));
      if (exp_commit >= 0) check({tag, " commit_cycle"}, commit_at, exp_commit);
    end
  endtask

  initial begin
    logic [7:0]  r0, r1, r2;
    logic [23:0] cat;
    tbl[0] = '{8'hA5, 8'h3C, 8'h0F, 0, 0, 20'hF3CA5, 24};
    tbl[1] = '{8'hA5, 8'h3C, 8'h0F, 5, 0, 20'hF3CA5, 29};
    tbl[2] = '{8'hA5, 8'h3C, 8'hFF, 0, 0, 20'hF3CA5, 24};
    tbl[3] = '{8'hA5, 8'h3C, 8'h0F, 0, 1, 20'hF3CA5, 24};
    tbl[4] = '{8'h12, 8'h34, 8'h56, 3, 0, 20'h63412, 27};

    // Reset held with start and in_valid asserted must keep every output low.
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outs", int'({in_ready, cfg_en, cfg_out, cfg_commit, busy, cfg_done}), 0);
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;

    for (int t = 0; t < 5; t++)
      run_load(tbl[t].w0, tbl[t].w1, tbl[t].w2, tbl[t].gap, tbl[t].mode, -1, (t != 0),
               tbl[t].exp_bits, tbl[t].exp_commit, $sformatf("vec%0d", t));

    // Reset in the middle of the second word, then a clean load from IDLE.
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 12, 1'b1, 20'hF3CA5, 24, "abort");
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, -1, 1'b0, 20'hF3CA5, 24, "after_abort");

    for (int n = 0; n < 20; n++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      cat = {r2, r1, r0};
      run_load(r0, r1, r2, 0, 2, -1, 1'b1, cat[19:0], -1, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
